// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and nibble helper for the seven-segment scanner
package seg_pkg;

   localparam int NUM_DIGITS  = 8;
   localparam int SEL_W       = 3;
   localparam int NIB_W       = 4;
   localparam int DATA_W      = 32;
   localparam int DEFAULT_DIV = 100000;

   function automatic logic [NIB_W-1:0] get_nib(input logic [DATA_W-1:0] word,
                                                input logic [SEL_W-1:0]  k);
      return word[k*NIB_W +: NIB_W];
   endfunction

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - data/load/control inputs and scan outputs of the scanner
interface seg_scan_if import seg_pkg::*; ();

   logic [DATA_W-1:0]     I_data;
   logic                  I_load;
   logic [NUM_DIGITS-1:0] I_en_mask;
   logic                  I_lz_sup;
   logic [NIB_W-1:0]      O_hex;
   logic [SEL_W-1:0]      O_sel;
   logic                  O_blank;
   logic                  O_pend;
   logic                  O_frame;

   modport master (
      output I_data, I_load, I_en_mask, I_lz_sup,
      input  O_hex, O_sel, O_blank, O_pend, O_frame
   );

   modport slave (
      input  I_data, I_load, I_en_mask, I_lz_sup,
      output O_hex, O_sel, O_blank, O_pend, O_frame
   );

endinterface

// File: rtl/seg_prescaler.sv
// rtl/seg_prescaler.sv - divides the clock down to one tick per digit period
module seg_prescaler #(
   parameter int DIV   = 100000,
   parameter int CNT_W = 24
) (
   input  logic I_clk,
   input  logic I_rst,
   output logic O_tick
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;

   // With DIV=1 the counter sits at zero and tick is permanently high.
   assign tick = (cnt_q == CNT_W'(DIV - 1));

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign O_tick = tick;

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - 8-digit scan sequencer with frame-aligned display update
module seg_scan import seg_pkg::*; #(
   parameter int DIV   = DEFAULT_DIV,
   parameter int CNT_W = 24
) (
   input  logic       I_clk,
   input  logic       I_rst,
   seg_scan_if.slave  bus
);

   logic                  tick, wrap;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [DATA_W-1:0]     disp_q, disp_d;
   logic [DATA_W-1:0]     pend_data_q, pend_data_d;
   logic                  pend_q, pend_d;
   logic [NIB_W-1:0]      hex_q, hex_d;
   logic                  blank_q, blank_d;
   logic                  frame_q, frame_d;
   logic                  lz, nz;

   seg_prescaler #(.DIV(DIV), .CNT_W(CNT_W)) u_prescaler (
      .I_clk  (I_clk),
      .I_rst  (I_rst),
      .O_tick (tick)
   );

   assign wrap = tick && (sel_q == SEL_W'(NUM_DIGITS - 1));

   always_comb begin
      sel_d       = tick ? sel_q + SEL_W'(1) : sel_q;
      pend_data_d = bus.I_load ? bus.I_data : pend_data_q;
      disp_d      = disp_q;
      pend_d      = pend_q;
      // A load landing on the boundary tick bypasses the pending slot.
      if (wrap) begin
         if (bus.I_load)  disp_d = bus.I_data;
         else if (pend_q) disp_d = pend_data_q;
         pend_d = 1'b0;
      end else if (bus.I_load) begin
         pend_d = 1'b1;
      end
   end

   always_comb begin
      nz = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if ((SEL_W'(k) >= sel_d) && (get_nib(disp_d, SEL_W'(k)) != '0)) nz = 1'b1;
      end
      lz = (sel_d != '0) && !nz;
   end

   always_comb begin
      hex_d   = hex_q;
      blank_d = blank_q;
      if (tick) begin
         hex_d   = get_nib(disp_d, sel_d);
         blank_d = ~bus.I_en_mask[sel_d] | (bus.I_lz_sup & lz);
      end
      frame_d = wrap;
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         sel_q       <= '0;
         disp_q      <= '0;
         pend_data_q <= '0;
         pend_q      <= 1'b0;
         hex_q       <= '0;
         blank_q     <= 1'b0;
         frame_q     <= 1'b0;
      end else begin
         sel_q       <= sel_d;
         disp_q      <= disp_d;
         pend_data_q <= pend_data_d;
         pend_q      <= pend_d;
         hex_q       <= hex_d;
         blank_q     <= blank_d;
         frame_q     <= frame_d;
      end
   end

   assign bus.O_hex   = hex_q;
   assign bus.O_sel   = sel_q;
   assign bus.O_blank = blank_q;
   assign bus.O_pend  = pend_q;
   assign bus.O_frame = frame_q;

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed scanner for the 8-digit seven-segment display. It sits directly upstream of the hex-to-segment decoder.
- Holds a 32-bit display word and steps a digit select through 0..7 at a divided rate. Each step presents the selected nibble (O_hex to the decoder's 4-bit value input) and the select (O_sel to the decoder's 3-bit digit-select input).
- A load handshake defers new data to the frame boundary so a frame never shows a mix of old and new digits.
- O_blank provides per-digit blanking; the top level uses it to force all digit enables inactive.

Parameters:
- DIV, 100000: clock cycles per digit; 1 kHz per digit at 100 MHz. Legal range 1..2^24.
- CNT_W, 24: prescaler counter width; must satisfy 2^CNT_W >= DIV.

Ports:
- I_clk  in  1  system clock, rising edge.
- I_rst  in  1  reset, synchronous, active-high.
- I_data  in  32  display word; digit k = I_data[4k+3:4k]; digit 7 is the most significant.
- I_load  in  1  single-cycle request to capture I_data.
- I_en_mask  in  8  per-digit enable; a 0 bit blanks that digit.
- I_lz_sup  in  1  leading-zero suppression enable.
- O_hex  out  4  nibble of the currently selected digit.
- O_sel  out  3  currently selected digit index.
- O_blank  out  1  1 = current digit must be dark.
- O_pend  out  1  1 = a loaded word is waiting for the frame boundary.
- O_frame  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (I_rst=1 at a clock edge): prescaler cnt=0, sel=0, disp=0, pend_data=0, pend=0, O_hex=0, O_sel=0, O_blank=0, O_pend=0, O_frame=0.
  - Reset mid-frame discards any pending word.
  - Reset has priority over every other input.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps to 0.
  - tick is high in the cycle where cnt==DIV-1.
  - With DIV=1, tick is high every cycle.
- Scan: on tick, sel <= sel+1 modulo 8. The wrap from 7 to 0 is the frame boundary.
- Load handshake:
  - I_load=1 sets pend_data <= I_data and pend <= 1. A load while pend=1 overwrites pend_data; last load wins.
  - At a frame-boundary tick with pend=1: disp <= pend_data, pend <= 0.
  - If I_load=1 in the same cycle as the frame-boundary tick, disp <= I_data directly and pend <= 0 (newest data wins).
  - A load in any other cycle never alters disp.
- Outputs:
  - All outputs are registered.
  - On tick, O_sel, O_hex and O_blank update in the same edge and are mutually coherent. They are computed from the next sel and the next disp (including a same-edge commit).
  - O_hex = disp_next[4*sel_next+3 : 4*sel_next].
  - O_blank = ~I_en_mask[sel_next] | (I_lz_sup & lz). lz = 1 when sel_next != 0 and every nibble from digit 7 down to sel_next of disp_next is zero. Digit 0 is therefore never suppressed; a value of 0 shows a single "0".
  - I_en_mask and I_lz_sup are sampled only on tick. Between ticks, O_hex, O_sel and O_blank are stable.
  - O_pend mirrors pend, registered.
  - O_frame = 1 for exactly the cycle following a frame-boundary tick, otherwise 0.
- Latency:
  - From I_load to visible data: 1 cycle after the next frame-boundary tick.
  - The worst case is 8*DIV cycles.

Decomposition:
- Package seg_pkg holds:
  - NUM_DIGITS=8, SEL_W=3, NIB_W=4, DATA_W=32.
  - DEFAULT_DIV=100000.
  - A function that extracts nibble k from a 32-bit word.
- One sub-module, seg_prescaler (parameters DIV and CNT_W; ports I_clk, I_rst, O_tick), generates tick.
- Top-level wiring:
  - O_hex goes to the decoder's value input; O_sel goes to its select input.
  - Digit enables = decoder_led | {8{O_blank}}.

Test Plan (DIV=4 unless noted):
- Reset, then load 32'h1234_5678 once → O_pend=1 until the first wrap. Over the next frame, on the ticks where O_sel steps 0..7, O_hex reads 8,7,6,5,4,3,2,1, each held 4 cycles. O_blank=0 throughout with mask 8'hFF.
- Load 32'hAAAA_AAAA mid-frame, then 32'h5555_5555 before the wrap → no digit ever shows A. After the wrap all digits show 5. O_frame pulses once per 32 cycles.
- I_load asserted exactly on the wrap tick with I_data=32'hDEAD_BEEF → the digit-0 output in the next cycle is F. O_pend stays 0.
- disp=32'h0000_0507, I_lz_sup=1, mask=8'hFF → O_blank=1 for sel 3..7, 0 for sel 0..2. With disp=0: only sel 0 is unblanked, with O_hex=0.
- Mask 8'b1010_0101 → O_blank=1 exactly at sel 1,3,4,6. Toggling the mask between ticks does not change O_blank until the next tick.
- Pending load, then I_rst held 1 cycle mid-frame → all outputs 0, O_pend=0, disp=0 after the next wrap. Repeat with DIV=1: sel advances every cycle.
